// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core -- full-duplex UART with TX/RX FIFOs and a 16x oversample tick.
//
// Build option: define UART_PARITY_EN to append a parity bit on TX and check
// it on RX (polarity chosen by parity_odd). Without it the frame is
// start + WORD_LEN data + stop bit(s), and parity_error never asserts.
//
// Parameters:
//   WORD_LEN  data bits per frame (5..9)
//   DEPTH     entries in each FIFO (power of 2, >= 2)
//   DIV_W     width of the runtime baud divisor
//
// Ports:
//   sys_clk, sys_rst_l       clock, asynchronous active-low reset
//   baud_div                 oversample tick period minus 1 (in sys_clk cycles)
//   two_stop                 two stop bits on TX (RX checks only the first)
//   parity_odd               odd (1) / even (0) parity
//   push_T, Din              write into the TX FIFO
//   tx_full, tx_busy         TX FIFO full; transmitter active or data queued
//   uart_XMIT_dataH          serial TX line, idles high
//   uart_REC_dataH           serial RX line (asynchronous)
//   pop_R, Dout, pndng_R     RX FIFO pop, show-ahead head, non-empty
//   rx_full                  RX FIFO full
//   parity_error, frame_error, overrun   one-cycle error pulses
// -----------------------------------------------------------------------------

// Simple synchronous FIFO with show-ahead head; full/empty from an occupancy
// count one bit wider than the pointers.
module uart_core_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s, do_pop_s;

    assign empty_o = (cnt_q == {(AW+1){1'b0}});
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rd_q];

    // Pointer/count next state; a push into a full FIFO is only taken when a
    // pop frees a slot in the same cycle.
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        wr_d      = do_push_s ? wr_q + AW'(1) : wr_q;
        rd_d      = do_pop_s  ? rd_q + AW'(1) : rd_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {(AW+1){1'b0}};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array (contents need no reset; empty masks the head).
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_q] <= din_i;
        end
    end
endmodule

module uart_core #(
    parameter int WORD_LEN = 8,
    parameter int DEPTH    = 16,
    parameter int DIV_W    = 12
) (
    input  logic                sys_clk,
    input  logic                sys_rst_l,
    input  logic [DIV_W-1:0]    baud_div,
    input  logic                two_stop,
    input  logic                parity_odd,
    input  logic                push_T,
    input  logic [WORD_LEN-1:0] Din,
    output logic                tx_full,
    output logic                tx_busy,
    output logic                uart_XMIT_dataH,
    input  logic                uart_REC_dataH,
    input  logic                pop_R,
    output logic [WORD_LEN-1:0] Dout,
    output logic                pndng_R,
    output logic                rx_full,
    output logic                parity_error,
    output logic                frame_error,
    output logic                overrun
);
`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam int BW = $clog2(WORD_LEN);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam state_e AFTER_DATA = PAR_EN ? ST_PARITY : ST_STOP;

    // Parity bit that makes the total ones count even (odd=0) or odd (odd=1).
    function automatic logic par_bit(input logic [WORD_LEN-1:0] d, input logic odd);
        par_bit = (^d) ^ odd;
    endfunction

    // ------------------------------------------------------------------ tick
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             reload_q, reload_d;
    logic             tick_s;

    // Down-counter: after reset the first cycle only loads baud_div, so the
    // first tick lands baud_div+1 cycles after release.
    always_comb begin
        tick_s   = 1'b0;
        reload_d = 1'b0;
        if (reload_q) begin
            baud_cnt_d = baud_div;
        end else if (baud_cnt_q == {DIV_W{1'b0}}) begin
            tick_s     = 1'b1;
            baud_cnt_d = baud_div;
        end else begin
            baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
    end

    // Tick counter registers.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            baud_cnt_q <= {DIV_W{1'b0}};
            reload_q   <= 1'b1;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            reload_q   <= reload_d;
        end
    end

    // -------------------------------------------------------------- TX path
    logic [WORD_LEN-1:0] tx_head_s;
    logic                tx_empty_s, tx_load_s;
    state_e              tx_state_q, tx_state_d;
    logic [3:0]          tx_tcnt_q, tx_tcnt_d;
    logic [BW-1:0]       tx_bit_q, tx_bit_d;
    logic [WORD_LEN-1:0] tx_shift_q, tx_shift_d;
    logic                tx_par_q, tx_par_d;
    logic                tx_two_q, tx_two_d;
    logic                tx_stop2_q, tx_stop2_d;
    logic                tx_line_q, tx_line_d;
    logic                tx_bit_end_s;

    uart_core_fifo #(.WIDTH(WORD_LEN), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_l),
        .push_i  (push_T),
        .pop_i   (tx_load_s),
        .din_i   (Din),
        .head_o  (tx_head_s),
        .full_o  (tx_full),
        .empty_o (tx_empty_s)
    );

    assign tx_busy         = (tx_state_q != ST_IDLE) || !tx_empty_s;
    assign uart_XMIT_dataH = tx_line_q;
    assign tx_bit_end_s    = tick_s && (tx_tcnt_q == 4'd15);

    // TX state register.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            tx_state_q <= ST_IDLE;
            tx_tcnt_q  <= 4'd0;
            tx_bit_q   <= {BW{1'b0}};
            tx_shift_q <= {WORD_LEN{1'b0}};
            tx_par_q   <= 1'b0;
            tx_two_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_two_q   <= tx_two_d;
            tx_stop2_q <= tx_stop2_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // TX next state. A frame is loaded from IDLE on a tick, or straight out of
    // the last STOP tick so queued words go out without an idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_two_d   = tx_two_q;
        tx_stop2_d = tx_stop2_q;
        tx_load_s  = 1'b0;
        if (!tick_s) begin
            tx_tcnt_d = tx_tcnt_q;
        end else if (tx_state_q == ST_IDLE) begin
            tx_tcnt_d = 4'd0;
        end else begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
        end
        case (tx_state_q)
            ST_IDLE: begin
                tx_load_s = tick_s & ~tx_empty_s;
            end
            ST_START: begin
                if (tx_bit_end_s) begin
                    tx_state_d = ST_DATA;
                end else begin
                    tx_state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (!tx_bit_end_s) begin
                    tx_state_d = ST_DATA;
                end else if (tx_bit_q == LAST_BIT) begin
                    tx_state_d = AFTER_DATA;
                end else begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + BW'(1);
                end
            end
            ST_PARITY: begin
                if (tx_bit_end_s) begin
                    tx_state_d = ST_STOP;
                end else begin
                    tx_state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (!tx_bit_end_s) begin
                    tx_state_d = ST_STOP;
                end else if (tx_two_q && !tx_stop2_q) begin
                    tx_stop2_d = 1'b1;
                end else if (!tx_empty_s) begin
                    tx_load_s = 1'b1;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
            end
        endcase
        if (tx_load_s) begin
            tx_state_d = ST_START;
            tx_tcnt_d  = 4'd0;
            tx_bit_d   = {BW{1'b0}};
            tx_shift_d = tx_head_s;
            tx_par_d   = par_bit(tx_head_s, parity_odd);
            tx_two_d   = two_stop;
            tx_stop2_d = 1'b0;
        end else begin
            tx_tcnt_d = tx_tcnt_d;
        end
    end

    // TX line value, computed from next state so the line register changes
    // on the same edge as the state.
    always_comb begin
        case (tx_state_d)
            ST_START:  tx_line_d = 1'b0;
            ST_DATA:   tx_line_d = tx_shift_d[0];
            ST_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    // -------------------------------------------------------------- RX path
    logic                rx_s1_q, rx_s2_q, rx_s3_q;
    logic                rx_fall_s;
    state_e              rx_state_q, rx_state_d;
    logic [3:0]          rx_tcnt_q, rx_tcnt_d;
    logic [BW-1:0]       rx_bit_q, rx_bit_d;
    logic [WORD_LEN-1:0] rx_shift_q, rx_shift_d;
    logic                rx_par_q, rx_par_d;
    logic                rx_samp_s, rx_stop_s;
    logic                rx_push_s, rx_empty_s;
    logic [WORD_LEN-1:0] rx_head_s;
    logic                par_err_q, par_err_d;
    logic                frm_err_q, frm_err_d;
    logic                ovr_q, ovr_d;

    uart_core_fifo #(.WIDTH(WORD_LEN), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_l),
        .push_i  (rx_push_s),
        .pop_i   (pop_R),
        .din_i   (rx_shift_q),
        .head_o  (rx_head_s),
        .full_o  (rx_full),
        .empty_o (rx_empty_s)
    );

    assign pndng_R      = !rx_empty_s;
    assign Dout         = rx_empty_s ? {WORD_LEN{1'b0}} : rx_head_s;
    assign parity_error = par_err_q;
    assign frame_error  = frm_err_q;
    assign overrun      = ovr_q;
    // rx_s3 holds the previous synchronised value for edge detection.
    assign rx_fall_s    = rx_s3_q & ~rx_s2_q;
    // START samples mid-bit after 8 ticks; later bits every 16 ticks.
    assign rx_samp_s    = tick_s && (rx_state_q != ST_IDLE) &&
                          (rx_tcnt_q == ((rx_state_q == ST_START) ? 4'd7 : 4'd15));
    assign rx_stop_s    = rx_samp_s && (rx_state_q == ST_STOP);

    // RX synchroniser, state and error pulse registers.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= {BW{1'b0}};
            rx_shift_q <= {WORD_LEN{1'b0}};
            rx_par_q   <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_s1_q    <= uart_REC_dataH;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovr_q      <= ovr_d;
        end
    end

    // RX next state. The tick phase counter restarts at each falling edge and
    // again at the start-bit sample so later samples stay mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        if (tick_s) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
        end else begin
            rx_tcnt_d = rx_tcnt_q;
        end
        case (rx_state_q)
            ST_IDLE: begin
                rx_tcnt_d = 4'd0;
                if (rx_fall_s) begin
                    rx_state_d = ST_START;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (!rx_samp_s) begin
                    rx_state_d = ST_START;
                end else if (rx_s2_q) begin
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_state_d = ST_DATA;
                    rx_tcnt_d  = 4'd0;
                    rx_bit_d   = {BW{1'b0}};
                end
            end
            ST_DATA: begin
                if (!rx_samp_s) begin
                    rx_state_d = ST_DATA;
                end else begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[WORD_LEN-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = AFTER_DATA;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (rx_samp_s) begin
                    rx_par_d   = rx_s2_q;
                    rx_state_d = ST_STOP;
                end else begin
                    rx_state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (rx_samp_s) begin
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_state_d = ST_STOP;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    // RX outputs at the stop sample: frame error beats overrun beats push;
    // parity error is reported alongside a push or an overrun.
    always_comb begin
        rx_push_s = 1'b0;
        frm_err_d = 1'b0;
        ovr_d     = 1'b0;
        par_err_d = 1'b0;
        if (rx_stop_s) begin
            if (!rx_s2_q) begin
                frm_err_d = 1'b1;
            end else if (rx_full) begin
                ovr_d = 1'b1;
            end else begin
                rx_push_s = 1'b1;
            end
            par_err_d = PAR_EN && rx_s2_q &&
                        (par_bit(rx_shift_q, parity_odd) != rx_par_q);
        end else begin
            rx_push_s = 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // start + 8 data + optional parity + one stop
    localparam int NBITS = PAR_EN ? 11 : 10;

    logic        sys_clk;
    logic        sys_rst_l;
    logic [11:0] baud_div;
    logic        two_stop, parity_odd;
    logic        push_T, pop_R;
    logic [7:0]  Din, Dout;
    logic        tx_full, tx_busy, uart_XMIT_dataH, uart_REC_dataH;
    logic        pndng_R, rx_full, parity_error, frame_error, overrun;
    logic        rx_drv, loop_en;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_par = 0, n_frm = 0, n_ovr = 0;
    int p0, f0, o0;

    assign uart_REC_dataH = loop_en ? uart_XMIT_dataH : rx_drv;

    uart_core #(.WORD_LEN(8), .DEPTH(16), .DIV_W(12)) dut (
        .sys_clk         (sys_clk),
        .sys_rst_l       (sys_rst_l),
        .baud_div        (baud_div),
        .two_stop        (two_stop),
        .parity_odd      (parity_odd),
        .push_T          (push_T),
        .Din             (Din),
        .tx_full         (tx_full),
        .tx_busy         (tx_busy),
        .uart_XMIT_dataH (uart_XMIT_dataH),
        .uart_REC_dataH  (uart_REC_dataH),
        .pop_R           (pop_R),
        .Dout            (Dout),
        .pndng_R         (pndng_R),
        .rx_full         (rx_full),
        .parity_error    (parity_error),
        .frame_error     (frame_error),
        .overrun         (overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Count error pulses so each scenario can check how many occurred.
    always @(posedge sys_clk) begin
        if (parity_error) n_par <= n_par + 1;
        if (frame_error)  n_frm <= n_frm + 1;
        if (overrun)      n_ovr <= n_ovr + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Expected line level for bit j of a frame (0 = start bit).
    function automatic logic frame_bit(input logic [7:0] d, input int j, input logic odd);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (PAR_EN && j == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic send_rx(input logic [7:0] d, input bit flip_par, input logic stop_val);
        for (int j = 0; j < NBITS; j++) begin
            rx_drv = frame_bit(d, j, parity_odd);
            if (PAR_EN && j == 9 && flip_par) rx_drv = ~rx_drv;
            if (j == NBITS - 1) rx_drv = stop_val;
            cyc(16);
        end
        rx_drv = 1'b1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        push_T = 1'b1;
        Din    = d;
        cyc(1);
        push_T = 1'b0;
    endtask

    // Waits (bounded) for the TX start bit; returns at the first low sample.
    task automatic wait_tx_start(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (uart_XMIT_dataH == 1'b0) begin
                found = 1'b1;
                break;
            end
            cyc(1);
        end
        check_eq(tag, found, 1'b1);
    endtask

    task automatic snap();
        p0 = n_par;
        f0 = n_frm;
        o0 = n_ovr;
    endtask

    task automatic pop_one();
        pop_R = 1'b1;
        cyc(1);
        pop_R = 1'b0;
    endtask

    initial begin
        sys_rst_l = 1'b1; baud_div = 12'd0; two_stop = 1'b0; parity_odd = 1'b0;
        push_T = 1'b0; pop_R = 1'b0; Din = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;
        #2 sys_rst_l = 1'b0;
        cyc(3);
        // ---- reset state
        check_eq("rst line", uart_XMIT_dataH, 1'b1);
        check_eq("rst tx_full", tx_full, 1'b0);
        check_eq("rst tx_busy", tx_busy, 1'b0);
        check_eq("rst pndng", pndng_R, 1'b0);
        check_eq("rst rx_full", rx_full, 1'b0);
        check_eq("rst Dout", Dout, 8'h00);
        check_eq("rst errors", {parity_error, frame_error, overrun}, 3'b000);
        sys_rst_l = 1'b1;
        cyc(5);

        // ---- TX frame of 0xA5, bit by bit at mid-bit
        push_tx(8'hA5);
        check_eq("tx busy queued", tx_busy, 1'b1);
        wait_tx_start("tx start");
        cyc(8);
        for (int j = 0; j < NBITS; j++) begin
            check_eq($sformatf("tx bit %0d", j), uart_XMIT_dataH, frame_bit(8'hA5, j, 1'b0));
            if (j < NBITS - 1) cyc(16);
        end
        cyc(7);
        check_eq("tx busy last cycle", tx_busy, 1'b1);
        cyc(1);
        check_eq("tx busy frame end", tx_busy, 1'b0);
        cyc(10);

        // ---- loopback of 0xA5
        snap();
        loop_en = 1'b1;
        push_tx(8'hA5);
        for (int i = 0; i < 400 && !pndng_R; i++) cyc(1);
        check_eq("loop pndng", pndng_R, 1'b1);
        check_eq("loop Dout", Dout, 8'hA5);
        cyc(20);
        check_eq("loop no errors", (n_par - p0) + (n_frm - f0) + (n_ovr - o0), 0);
        pop_one();
        check_eq("loop popped", pndng_R, 1'b0);
        loop_en = 1'b0;
        cyc(10);

        // ---- flipped parity bit (without parity the frame is plain)
        snap();
        send_rx(8'hA5, 1'b1, 1'b1);
        cyc(10);
        check_eq("par err count", n_par - p0, PAR_EN ? 1 : 0);
        check_eq("par pndng", pndng_R, 1'b1);
        check_eq("par Dout", Dout, 8'hA5);
        check_eq("par no frame err", n_frm - f0, 0);
        pop_one();

        // ---- stop bit low
        snap();
        send_rx(8'h3C, 1'b0, 1'b0);
        cyc(10);
        check_eq("frm err count", n_frm - f0, 1);
        check_eq("frm pndng", pndng_R, 1'b0);
        check_eq("frm no par err", n_par - p0, 0);

        // ---- 17 frames without popping
        snap();
        for (int i = 0; i < 17; i++) begin
            send_rx(8'h10 + 8'(i), 1'b0, 1'b1);
            if (i == 14) begin
                cyc(2);
                check_eq("rx not full at 15", rx_full, 1'b0);
            end
            if (i == 15) begin
                cyc(2);
                check_eq("rx full at 16", rx_full, 1'b1);
                check_eq("no overrun at 16", n_ovr - o0, 0);
            end
        end
        cyc(10);
        check_eq("overrun count", n_ovr - o0, 1);
        check_eq("overrun head", Dout, 8'h10);
        check_eq("overrun still full", rx_full, 1'b1);
        check_eq("overrun no other err", (n_par - p0) + (n_frm - f0), 0);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("drain %0d", i), Dout, 8'h10 + 8'(i));
            pop_one();
        end
        check_eq("drained", pndng_R, 1'b0);

        // ---- 8-cycle glitch on idle line, then a good frame
        snap();
        rx_drv = 1'b0;
        cyc(8);
        rx_drv = 1'b1;
        cyc(40);
        check_eq("glitch pndng", pndng_R, 1'b0);
        check_eq("glitch no pulse", (n_par - p0) + (n_frm - f0) + (n_ovr - o0), 0);
        send_rx(8'h5A, 1'b0, 1'b1);
        cyc(10);
        check_eq("post glitch pndng", pndng_R, 1'b1);
        check_eq("post glitch Dout", Dout, 8'h5A);
        pop_one();

        // ---- two stop bits lengthen the frame by one bit time
        two_stop = 1'b1;
        push_tx(8'hFF);
        wait_tx_start("two stop start");
        two_stop = 1'b0;
        cyc(16 * (NBITS + 1) - 1);
        check_eq("two stop busy", tx_busy, 1'b1);
        cyc(1);
        check_eq("two stop done", tx_busy, 1'b0);
        cyc(5);

        // ---- reset during data bit 4 with a second word queued
        push_tx(8'hC3);
        push_tx(8'h81);
        wait_tx_start("rst tx start");
        cyc(8 + 16 * 5);
        check_eq("pre rst bit4", uart_XMIT_dataH, 1'b0);
        sys_rst_l = 1'b0;
        #1;
        check_eq("mid rst line", uart_XMIT_dataH, 1'b1);
        check_eq("mid rst busy", tx_busy, 1'b0);
        cyc(2);
        sys_rst_l = 1'b1;
        cyc(30);
        check_eq("post rst busy", tx_busy, 1'b0);
        check_eq("post rst line", uart_XMIT_dataH, 1'b1);
        check_eq("post rst pndng", pndng_R, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter WORD_LEN, default 8, meaning data bits per frame (5..9).
REQ-002 SHALL have parameter DEPTH, default 16, meaning TX and RX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter DIV_W, default 12, meaning width of the runtime baud divisor.
REQ-004 Ports:
- sys_clk  in  1  sole clock.
- sys_rst_l  in  1  reset; one clock; reset is asynchronous and active-low.
- baud_div  in  DIV_W  oversample tick period minus 1, in sys_clk cycles.
- two_stop  in  1  1 = two stop bits on TX; RX checks the first stop bit only.
- parity_odd  in  1  1 = odd parity, 0 = even parity; used only when UART_PARITY_EN is defined.
- push_T  in  1  write Din into the TX FIFO.
- Din  in  WORD_LEN  TX data.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FSM not IDLE, or TX FIFO non-empty.
- uart_XMIT_dataH  out  1  serial TX line; idles high.
- uart_REC_dataH  in  1  serial RX line; asynchronous to sys_clk.
- pop_R  in  1  remove the RX FIFO head.
- Dout  out  WORD_LEN  RX FIFO head (show-ahead); valid while pndng_R=1.
- pndng_R  out  1  RX FIFO non-empty.
- rx_full  out  1  RX FIFO full.
- parity_error, frame_error, overrun  out  1 each  one-cycle error pulses.

Function
REQ-005 Tick counter SHALL reload baud_div and emit a one-cycle tick on reaching 0. Ticks are 16 per bit; baud_div=0 gives a tick every cycle. A new baud_div value takes effect at the next reload.
REQ-006 Each FIFO SHALL follow these rules:
- push when full is ignored; pop when empty is ignored.
- simultaneous push and pop on a non-empty FIFO SHALL do both, count unchanged.
- pointers wrap modulo DEPTH; full/empty are derived from a count of width log2(DEPTH)+1.
REQ-007 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a tick with the FIFO non-empty; pops the FIFO and loads the shift register in the same cycle.
- each state holds for 16 ticks.
- DATA is sent LSB first, WORD_LEN bits.
- DATA -> PARITY (macro defined) or STOP.
- STOP lasts 1 or 2 bit times per two_stop sampled at START, then -> IDLE.
REQ-008 Back-to-back TX frames SHALL have no idle gap when the FIFO is non-empty at the end of STOP.
REQ-009 RX input SHALL pass a 2-flop synchroniser before any use.
REQ-010 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a synchronised falling edge; the tick phase counter resets.
- at tick 8 of START, line high -> IDLE (false start, no pulse); line low -> DATA.
- each subsequent bit is sampled 16 ticks after the previous sample.
REQ-011 At the STOP sample, RX SHALL act as follows:
- line low: frame_error pulses and the word is discarded.
- else, RX FIFO full: overrun pulses and the word is discarded.
- else: the word is pushed.
- the FSM then -> IDLE.
REQ-012 A parity mismatch SHALL pulse parity_error in the STOP-sample cycle; the word is still pushed, subject to REQ-011.
REQ-013 A pop_R issued in the same cycle as an RX push SHALL follow REQ-006.
REQ-014 All error pulses SHALL last exactly one sys_clk cycle and are mutually exclusive, except parity_error may coincide with overrun.

Reset
REQ-015 On sys_rst_l low, the block SHALL asynchronously enter the following state:
- both FSMs IDLE; FIFOs empty; tick counter = baud_div reload pending.
- uart_XMIT_dataH=1; tx_full=0; tx_busy=0; pndng_R=0; rx_full=0; Dout=0; all error pulses 0.
REQ-016 Reset asserted mid-frame SHALL abort the frame: no partial word is pushed, and the TX line returns high immediately.
REQ-017 Reset release SHALL be used synchronously: the first tick occurs baud_div+1 cycles after deassertion.

Configuration
REQ-018 Macro UART_PARITY_EN:
- defined: a parity bit is appended on TX and checked on RX per parity_odd; frame = 1+WORD_LEN+1+stop bits.
- undefined: no PARITY state, parity_odd is ignored, parity_error is tied 0, frame = 1+WORD_LEN+stop bits.

Verification
REQ-019 Bench SHALL cover these directed scenarios (WORD_LEN=8, DEPTH=16, baud_div=0, UART_PARITY_EN defined, parity_odd=0, two_stop=0):
- push 0xA5 -> TX line 0,1,0,1,0,0,1,0,1,0(parity),1; each bit 16 cycles; frame 176 cycles.
- 0xA5 looped back TX->RX -> pndng_R=1, Dout=0xA5, no error pulse; same frame with parity bit flipped -> parity_error pulse, Dout=0xA5.
- RX frame with stop bit 0 -> frame_error pulse, pndng_R stays 0.
- 17 RX frames with no pop -> rx_full=1 after 16; 17th -> overrun pulse, head still the first word.
- 8-cycle low glitch on idle RX line -> no push, no pulse, FSM back to IDLE.
- reset asserted at bit 4 of a TX frame -> uart_XMIT_dataH=1 and tx_busy=0 immediately; FIFO empty after release.
